gap_score_argmax: RTL

Parametrised classifier head for the ECG accelerator. It consumes the staggered per-channel max-pool outputs of the final conv layer. For each channel it accumulates non-negative and negative samples separately over one frame, then forms a piecewise-linear score per class, y_k = P_k·cp_k + N_k·cn_k + FRAME_LEN·b_k. It selects the arg-max class and signals the result with a one-cycle valid pulse. Coefficients are run-time ports, so retrained models need no RTL change.

---
 rtl/gap_score_argmax_pkg.sv | 15 +
 rtl/gap_score_argmax_if.sv | 29 ++
 rtl/gap_score_argmax_split_accum.sv | 54 +++++
 rtl/gap_score_argmax.sv | 111 +++++++++++
 4 files changed

// File: rtl/gap_score_argmax_pkg.sv
// gap_score_argmax_pkg: shared FSM state type, index-width helper and accumulator limits
package gap_score_argmax_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, SCORE, DONE} state_e;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic longint acc_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint acc_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/gap_score_argmax_if.sv
// gap_score_argmax_if: frame control, sample stream, coefficients and result bundle
interface gap_score_argmax_if #(
  parameter int NUM_CLASS = 5,
  parameter int DATA_W    = 10,
  parameter int COEF_W    = 11,
  parameter int BIAS_W    = 14,
  parameter int SCORE_W   = 29,
  parameter int CLS_W     = gap_score_argmax_pkg::clog2(NUM_CLASS)
);
  logic                          frame_start;
  logic [NUM_CLASS-1:0]          in_valid;
  logic [NUM_CLASS*DATA_W-1:0]   in_data;
  logic [NUM_CLASS*COEF_W-1:0]   coef_pos;
  logic [NUM_CLASS*COEF_W-1:0]   coef_neg;
  logic [NUM_CLASS*BIAS_W-1:0]   bias;
  logic                          busy;
  logic                          result_valid;
  logic [CLS_W-1:0]              result_class;
  logic [SCORE_W-1:0]            result_score;
  logic                          sat_flag;
  modport master (
    output frame_start, in_valid, in_data, coef_pos, coef_neg, bias,
    input  busy, result_valid, result_class, result_score, sat_flag
  );
  modport slave (
    input  frame_start, in_valid, in_data, coef_pos, coef_neg, bias,
    output busy, result_valid, result_class, result_score, sat_flag
  );
endinterface

// File: rtl/gap_score_argmax_split_accum.sv
// split_accum: one channel's saturating non-negative/negative sums and sample count
module split_accum
  import gap_score_argmax_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 27,
  parameter int ACC_W     = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [ACC_W-1:0]  p,
  output logic signed [ACC_W-1:0]  n,
  output logic                     done,
  output logic                     sat
);
  localparam int CNT_W = clog2(FRAME_LEN + 1);
  localparam logic signed [ACC_W:0] P_MAX = (ACC_W + 1)'(acc_max(ACC_W));
  localparam logic signed [ACC_W:0] N_MIN = (ACC_W + 1)'(acc_min(ACC_W));
  logic signed [ACC_W-1:0] p_q, p_d, n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d, take, neg;
  logic signed [ACC_W:0] d_ext, p_sum, n_sum;
  assign done = cnt_q == CNT_W'(FRAME_LEN);
  assign p = p_q;
  assign n = n_q;
  assign sat = sat_q;
  always_comb begin
    neg = in_data[DATA_W-1];
    take = en && in_valid && !done && !clr;
    d_ext = {{(ACC_W + 1 - DATA_W){in_data[DATA_W-1]}}, in_data};
    p_sum = {p_q[ACC_W-1], p_q} + d_ext;
    n_sum = {n_q[ACC_W-1], n_q} + d_ext;
    p_d = clr ? '0 : (take && !neg) ? (p_sum > P_MAX ? P_MAX[ACC_W-1:0] : p_sum[ACC_W-1:0]) : p_q;
    n_d = clr ? '0 : (take && neg) ? (n_sum < N_MIN ? N_MIN[ACC_W-1:0] : n_sum[ACC_W-1:0]) : n_q;
    cnt_d = clr ? '0 : cnt_q + CNT_W'(take);
    sat_d = clr ? 1'b0 : sat_q | (take && (neg ? n_sum < N_MIN : p_sum > P_MAX));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      p_q <= p_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
endmodule

// File: rtl/gap_score_argmax.sv
// gap_score_argmax: per-channel split accumulation, time-shared piecewise-linear scoring
// and arg-max over classes with a one-cycle result pulse.
module gap_score_argmax
  import gap_score_argmax_pkg::*;
#(
  parameter int NUM_CLASS = 5,
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 27,
  parameter int ACC_W     = 15,
  parameter int COEF_W    = 11,
  parameter int BIAS_W    = 14,
  parameter int SCORE_W   = 29
) (
  input  logic clk,
  input  logic rst_n,
  gap_score_argmax_if.slave bus
);
  localparam int CLS_W = clog2(NUM_CLASS);
  localparam logic [CLS_W-1:0] LAST = CLS_W'(NUM_CLASS - 1);
  localparam logic [SCORE_W-1:0] FLEN = SCORE_W'(FRAME_LEN);
  state_e state_q, state_d;
  logic [CLS_W-1:0] idx_q, idx_d, arg_q, arg_d, res_class_q, res_class_d;
  logic signed [SCORE_W-1:0] max_q, max_d, res_score_q, res_score_d, y;
  logic signed [ACC_W-1:0] p_acc [NUM_CLASS];
  logic signed [ACC_W-1:0] n_acc [NUM_CLASS];
  logic [COEF_W-1:0] cp [NUM_CLASS];
  logic [COEF_W-1:0] cn [NUM_CLASS];
  logic [BIAS_W-1:0] b [NUM_CLASS];
  logic [NUM_CLASS-1:0] done, sat;
  logic [SCORE_W-1:0] pe, ne, cpe, cne, be;
  logic better;
  for (genvar k = 0; k < NUM_CLASS; k++) begin : g_ch
    assign cp[k] = bus.coef_pos[k*COEF_W +: COEF_W];
    assign cn[k] = bus.coef_neg[k*COEF_W +: COEF_W];
    assign b[k]  = bus.bias[k*BIAS_W +: BIAS_W];
    split_accum #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W)) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.frame_start),
      .en       (state_q == ACCUM),
      .in_valid (bus.in_valid[k]),
      .in_data  (bus.in_data[k*DATA_W +: DATA_W]),
      .p        (p_acc[k]),
      .n        (n_acc[k]),
      .done     (done[k]),
      .sat      (sat[k])
    );
  end
  // Only the low SCORE_W bits matter, so the sign-extended operands multiply correctly unsigned.
  assign pe  = {{(SCORE_W - ACC_W){p_acc[idx_q][ACC_W-1]}}, p_acc[idx_q]};
  assign ne  = {{(SCORE_W - ACC_W){n_acc[idx_q][ACC_W-1]}}, n_acc[idx_q]};
  assign cpe = {{(SCORE_W - COEF_W){1'b0}}, cp[idx_q]};
  assign cne = {{(SCORE_W - COEF_W){1'b0}}, cn[idx_q]};
  assign be  = {{(SCORE_W - BIAS_W){b[idx_q][BIAS_W-1]}}, b[idx_q]};
  always_comb begin
    y = pe * cpe + ne * cne + be * FLEN;
    better = (idx_q == '0) || (y > max_q);
    state_d = state_q;
    idx_d = idx_q;
    max_d = max_q;
    arg_d = arg_q;
    res_class_d = res_class_q;
    res_score_d = res_score_q;
    case (state_q)
      IDLE: state_d = IDLE;
      ACCUM: if (&done) begin
        state_d = SCORE;
        idx_d = '0;
      end
      SCORE: begin
        max_d = better ? y : max_q;
        arg_d = better ? idx_q : arg_q;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          res_class_d = arg_d;
          res_score_d = max_d;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.frame_start) begin
      state_d = ACCUM;
      idx_d = '0;
      max_d = '0;
      arg_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      max_q <= '0;
      arg_q <= '0;
      res_class_q <= '0;
      res_score_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      max_q <= max_d;
      arg_q <= arg_d;
      res_class_q <= res_class_d;
      res_score_q <= res_score_d;
    end
  assign bus.busy = (state_q == ACCUM) || (state_q == SCORE);
  assign bus.result_valid = state_q == DONE;
  assign bus.result_class = res_class_q;
  assign bus.result_score = res_score_q;
  assign bus.sat_flag = |sat;
endmodule
